i2c_target_rx: RTL and testbench
================================

# i2c_target_rx

Write-only I2C target (slave) that receives the 3-byte write transactions the audio-codec configuration path emits: a 7-bit device address plus write bit, then two data bytes. It acknowledges each accepted byte by pulling SDAT low and presents the 16-bit payload to on-chip logic with a one-cycle valid strobe. It stands in for the codec on the bench and in loopback builds, oversampling SCLK/SDAT on the system clock.

## Interface

- `DEV_ADDR`, default 7'h1A, the 7-bit address this target answers to. 0x34 is the write byte on the wire.
- `clk` in, 1 bit: system clock. It must be ≥ 8× the SCLK rate; SCLK at clk/128 is the normal case.
- `rst_n` in, 1 bit: asynchronous, active-low reset.
- `i2c_sclk` in, 1 bit: bus clock, driven by the initiator.
- `i2c_sdat` inout, 1 bit: open-drain data line. The block drives only 1'b0 or 1'bz and relies on the external pull-up.
- `data_out` out, 16 bits: last accepted payload. Bits {byte1, byte2}, MSB first.
- `data_valid` out, 1 bit: one-cycle strobe when `data_out` updates.
- `busy` out, 1 bit: high from START detection until STOP detection.
- `error` out, 1 bit: one-cycle strobe on a protocol violation for an addressed transaction.

## Operation

- **Input conditioning.** Two-flop synchronizers on SCLK and SDAT, plus one previous-sample register each. All edge and condition detection uses the synchronized signals only.
- **START / STOP detection.**
  - START or repeated START: synchronized SCL high and SDA falling.
  - STOP: synchronized SCL high and SDA rising.
  - These conditions take priority over any state.
- **State machine.**
  - `IDLE`: waits for START. `busy`=0.
  - `ADDR`: shifts in 8 bits, one on each SCL rising edge, MSB first.
    - After the 8th bit, if [7:1]==DEV_ADDR and [0]==0, go to `ADDR_ACK`.
    - Otherwise go to `IGNORE`. A read request or wrong address is not acknowledged.
  - `ADDR_ACK` / `DATA_ACK`: drive SDAT low from the SCL falling edge after bit 8 until the SCL falling edge after the 9th clock. Then release.
  - `DATA`: shifts in 8 bits. A 2-bit byte counter selects the high or low half of the shift register.
    - Byte 1 and byte 2 go to `DATA_ACK`.
    - A 3rd or later byte is not ACKed, pulses `error`, and goes to `IGNORE`.
  - `IGNORE`: SDAT released. Waits for STOP (go to `IDLE`) or START (go to `ADDR`).
- **Output commit.** At the release edge ending the byte-2 ACK, load `data_out` with {byte1, byte2} and pulse `data_valid`.
- **Abort.** STOP or repeated START before the byte-2 ACK completes, in an addressed transaction:
  - The partial payload is discarded.
  - `error` pulses and there is no `data_valid`.
  - SDAT is released immediately.
- **Unaddressed transactions** never raise `error`.

## Timing

- **Reset values.** `data_out`=16'h0000, `data_valid`=0, `busy`=0, `error`=0. SDAT is released (z), the state is `IDLE`, and the counters are 0.
- **Reset assertion** releases SDAT combinationally in the same cycle, including mid-ACK.
- **Detection latency.** Pin edges are seen 3 clk later: 2 synchronizer cycles plus 1 edge-detect cycle.
- **ACK timing.**
  - SDAT goes low 1 clk after the detected falling edge following bit 8. That is ≤4 clk after the pin edge, which is well inside the SCL low phase.
  - SDAT goes high 1 clk after the detected falling edge that ends the 9th clock.
  - SDAT is never changed while synchronized SCL is high.
- **`data_valid`** rises 1 clk after the release edge ending the byte-2 ACK. It stays high for exactly 1 cycle. `data_out` holds until the next commit.
- **`busy`** rises 1 clk after START detection and falls 1 clk after STOP detection.
- **Simultaneous events.** START/STOP detection overrides a same-cycle SCL edge.

## Test plan

1. **Normal write.** Initiator writes 0x34, 0x1E, 0x00 at SCLK=clk/128.
   - Required: SDAT is low during the 9th, 18th and 27th SCLK high phases.
   - Required: one `data_valid` pulse with `data_out`=16'h1E00, and `error` stays 0.
2. **Wrong address.** Write 0x36, 0xAA, 0x55.
   - Required: no SDAT low at any ACK slot, no `data_valid`, no `error`.
   - Required: `busy`=1 until STOP.
3. **Read request.** Send 0x35 (read bit set).
   - Required: NACK on SDAT and `IGNORE` behaviour, with `data_out` unchanged.
4. **Early STOP.** Send 0x34, 0x12, then STOP.
   - Required: two ACKs, one `error` pulse at the STOP, no `data_valid`, `data_out` unchanged.
5. **Extra byte.** Send 0x34, 0xAB, 0xCD, 0xEF.
   - Required: `data_valid` with 16'hABCD after the 2nd data ACK.
   - Required: the 4th byte is NACKed and `error` pulses once.
   - Then a repeated START, 0x34, 0x01, 0x02 gives `data_valid` with 16'h0102.
6. **Reset mid-ACK.** Assert `rst_n`=0 while SDAT is held low.
   - Required: SDAT is z in the same cycle, and all outputs hold their reset values.
   - Required: after release, the next full transaction behaves as in scenario 1.

Source files
------------

// File: rtl/i2c_target_rx.sv
// Write-only I2C target: accepts address + two data bytes and presents the 16-bit payload.
// SCLK/SDAT are oversampled on clk; SDAT is only ever pulled low or released.
`timescale 1ns/1ps
module i2c_target_rx #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i2c_sclk,
    inout  wire         i2c_sdat,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic        busy,
    output logic        error
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] DATA     = 3'd3;
    localparam logic [2:0] DATA_ACK = 3'd4;
    localparam logic [2:0] IGNORE   = 3'd5;

    logic       scl_s1, scl_s2, scl_prev;
    logic       sda_s1, sda_s2, sda_prev;
    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [1:0] byte_cnt;
    logic [6:0] shift;
    logic [15:0] payload;
    logic       sda_drive;

    logic       scl_rise, scl_fall, start_det, stop_det, abort_pending;
    logic [7:0] next_byte;

    // Synchronizers reset to the idle-bus level so reset release never looks like a bus condition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_prev <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_s1   <= i2c_sclk;
            scl_s2   <= scl_s1;
            scl_prev <= scl_s2;
            sda_s1   <= i2c_sdat;
            sda_s2   <= sda_s1;
            sda_prev <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_prev;
    assign scl_fall  = ~scl_s2 & scl_prev;
    assign start_det = scl_s2 & sda_prev & ~sda_s2;
    assign stop_det  = scl_s2 & ~sda_prev & sda_s2;
    assign next_byte = {shift, sda_s2};

    // An addressed transaction still owes us its byte-2 ACK; ending it here is an abort
    assign abort_pending = (state == ADDR_ACK) || (state == DATA_ACK) ||
                           ((state == DATA) && (byte_cnt != 2'd2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 2'd0;
            shift      <= 7'd0;
            payload    <= 16'h0000;
            sda_drive  <= 1'b0;
            data_out   <= 16'h0000;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            error      <= 1'b0;
            if (start_det) begin
                if (abort_pending) error <= 1'b1;
                state     <= ADDR;
                bit_cnt   <= 3'd0;
                byte_cnt  <= 2'd0;
                sda_drive <= 1'b0;
                busy      <= 1'b1;
            end else if (stop_det) begin
                if (abort_pending) error <= 1'b1;
                state     <= IDLE;
                bit_cnt   <= 3'd0;
                byte_cnt  <= 2'd0;
                sda_drive <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ADDR, DATA: begin
                        if (scl_rise) begin
                            shift <= next_byte[6:0];
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= 3'd0;
                                if (state == ADDR) begin
                                    if ((next_byte[7:1] == DEV_ADDR) && !next_byte[0])
                                        state <= ADDR_ACK;
                                    else
                                        state <= IGNORE;
                                end else if (byte_cnt == 2'd2) begin
                                    error <= 1'b1;
                                    state <= IGNORE;
                                end else begin
                                    if (byte_cnt == 2'd0)
                                        payload[15:8] <= next_byte;
                                    else
                                        payload[7:0] <= next_byte;
                                    byte_cnt <= byte_cnt + 2'd1;
                                    state    <= DATA_ACK;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    // First falling edge starts the ACK, the second (end of 9th clock) ends it
                    ADDR_ACK, DATA_ACK: begin
                        if (scl_fall) begin
                            if (!sda_drive) begin
                                sda_drive <= 1'b1;
                            end else begin
                                sda_drive <= 1'b0;
                                state     <= DATA;
                                if ((state == DATA_ACK) && (byte_cnt == 2'd2)) begin
                                    data_out   <= payload;
                                    data_valid <= 1'b1;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Gated with rst_n so an ACK in progress is dropped the moment reset asserts
    assign i2c_sdat = (sda_drive && rst_n) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Self-checking bench for i2c_target_rx: a bit-banged I2C initiator, a vector table of
// transactions and a scoreboard queue of expected payloads checked at each data_valid.
`timescale 1ns/1ps
module tb_i2c_target_rx;

    localparam int Q = 32;
    localparam int H = 64;

    typedef struct {
        logic [31:0] bytes;
        int          nbytes;
        logic [3:0]  exp_ack;
        int          exp_valid;
        logic [15:0] exp_data;
        int          exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_low = 1'b0;
    wire         sda_bus;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;
    logic        error;

    int          checks = 0;
    int          failures = 0;
    int          valid_cnt = 0;
    int          err_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] last_data = 16'h0000;
    vec_t        vecs[8];

    assign sda_bus = sda_low ? 1'b0 : 1'bz;
    pullup (sda_bus);

    always #5 clk = ~clk;

    i2c_target_rx #(.DEV_ADDR(7'h1A)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i2c_sclk  (scl),
        .i2c_sdat  (sda_bus),
        .data_out  (data_out),
        .data_valid(data_valid),
        .busy      (busy),
        .error     (error)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard: every data_valid must match the oldest queued payload
    always @(negedge clk) begin
        if (rst_n) begin
            if (error) err_cnt++;
            if (data_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL spurious data_valid: data_out 0x%0h, no payload expected", data_out);
                end else begin
                    checkOutput("data_out at data_valid", {16'h0, data_out}, {16'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Works both from an idle bus and as a repeated START with SCL low
    task automatic i2cStart();
        sda_low = 1'b0;
        waitClk(Q);
        scl = 1'b1;
        waitClk(Q);
        sda_low = 1'b1;
        waitClk(Q);
        scl = 1'b0;
        waitClk(Q);
    endtask

    task automatic i2cStop();
        sda_low = 1'b1;
        waitClk(Q);
        scl = 1'b1;
        waitClk(Q);
        sda_low = 1'b0;
        waitClk(Q);
    endtask

    task automatic sendBit(input logic b);
        sda_low = ~b;
        waitClk(Q);
        scl = 1'b1;
        waitClk(H);
        scl = 1'b0;
        waitClk(Q);
    endtask

    task automatic writeByte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) sendBit(b[i]);
        sda_low = 1'b0;
        waitClk(Q);
        scl = 1'b1;
        waitClk(H / 2);
        ack = (sda_bus === 1'b0);
        waitClk(H / 2);
        scl = 1'b0;
        waitClk(Q);
    endtask

    task automatic applyStimulus(input vec_t v, output logic [3:0] acks, output logic busy_mid);
        logic a;
        acks = 4'b0000;
        i2cStart();
        if (v.exp_valid != 0) exp_q.push_back(v.exp_data);
        for (int i = 0; i < v.nbytes; i++) begin
            writeByte(v.bytes[31 - 8 * i -: 8], a);
            acks[i] = a;
        end
        busy_mid = busy;
        i2cStop();
        waitClk(16);
    endtask

    task automatic runVector(input int k);
        logic [3:0] acks;
        logic       busy_mid;
        int         v0, e0;
        v0 = valid_cnt;
        e0 = err_cnt;
        applyStimulus(vecs[k], acks, busy_mid);
        if (vecs[k].exp_valid != 0) last_data = vecs[k].exp_data;
        for (int i = 0; i < vecs[k].nbytes; i++)
            checkOutput($sformatf("v%0d ack byte %0d", k, i), {31'h0, acks[i]}, {31'h0, vecs[k].exp_ack[i]});
        checkOutput($sformatf("v%0d data_valid count", k), valid_cnt - v0, vecs[k].exp_valid);
        checkOutput($sformatf("v%0d error count", k), err_cnt - e0, vecs[k].exp_err);
        checkOutput($sformatf("v%0d data_out", k), {16'h0, data_out}, {16'h0, last_data});
        checkOutput($sformatf("v%0d busy before STOP", k), {31'h0, busy_mid}, 32'h1);
        checkOutput($sformatf("v%0d busy after STOP", k), {31'h0, busy}, 32'h0);
        checkOutput($sformatf("v%0d scoreboard drained", k), exp_q.size(), 0);
    endtask

    initial begin
        #900_000;
        failures++;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [6:0] acks7;
        logic       a;
        int         v0, e0;

        vecs[0] = '{bytes: 32'h341E0000, nbytes: 3, exp_ack: 4'b0111, exp_valid: 1, exp_data: 16'h1E00, exp_err: 0};
        vecs[1] = '{bytes: 32'h36AA5500, nbytes: 3, exp_ack: 4'b0000, exp_valid: 0, exp_data: 16'h0000, exp_err: 0};
        vecs[2] = '{bytes: 32'h35110000, nbytes: 2, exp_ack: 4'b0000, exp_valid: 0, exp_data: 16'h0000, exp_err: 0};
        vecs[3] = '{bytes: 32'h34120000, nbytes: 2, exp_ack: 4'b0011, exp_valid: 0, exp_data: 16'h0000, exp_err: 1};
        vecs[4] = '{bytes: 32'h34ABCDEF, nbytes: 4, exp_ack: 4'b0111, exp_valid: 1, exp_data: 16'hABCD, exp_err: 1};
        vecs[5] = '{bytes: 32'h3400FF00, nbytes: 3, exp_ack: 4'b0111, exp_valid: 1, exp_data: 16'h00FF, exp_err: 0};
        vecs[6] = '{bytes: 32'h34000000, nbytes: 1, exp_ack: 4'b0001, exp_valid: 0, exp_data: 16'h0000, exp_err: 1};
        vecs[7] = '{bytes: 32'h68220000, nbytes: 2, exp_ack: 4'b0000, exp_valid: 0, exp_data: 16'h0000, exp_err: 0};

        waitClk(4);
        checkOutput("reset data_out", {16'h0, data_out}, 32'h0);
        checkOutput("reset data_valid", {31'h0, data_valid}, 32'h0);
        checkOutput("reset busy", {31'h0, busy}, 32'h0);
        checkOutput("reset error", {31'h0, error}, 32'h0);
        checkOutput("reset sdat released", {31'h0, sda_bus}, 32'h1);
        rst_n = 1'b1;
        waitClk(8);

        for (int k = 0; k < 8; k++) runVector(k);

        // Extra byte, then repeated START straight into a fresh transaction
        $display("[TB] repeated START sequence");
        v0 = valid_cnt;
        e0 = err_cnt;
        acks7 = 7'd0;
        i2cStart();
        exp_q.push_back(16'hABCD);
        writeByte(8'h34, a); acks7[0] = a;
        writeByte(8'hAB, a); acks7[1] = a;
        writeByte(8'hCD, a); acks7[2] = a;
        writeByte(8'hEF, a); acks7[3] = a;
        i2cStart();
        exp_q.push_back(16'h0102);
        writeByte(8'h34, a); acks7[4] = a;
        writeByte(8'h01, a); acks7[5] = a;
        writeByte(8'h02, a); acks7[6] = a;
        i2cStop();
        waitClk(16);
        last_data = 16'h0102;
        checkOutput("rs acks", {25'h0, acks7}, {25'h0, 7'b1110111});
        checkOutput("rs data_valid count", valid_cnt - v0, 2);
        checkOutput("rs error count", err_cnt - e0, 1);
        checkOutput("rs data_out", {16'h0, data_out}, {16'h0, last_data});
        checkOutput("rs scoreboard drained", exp_q.size(), 0);

        // Reset while the target is holding the address ACK low
        $display("[TB] reset during ACK sequence");
        i2cStart();
        for (int i = 7; i >= 0; i--) sendBit(logic'((8'h34 >> i) & 8'h01));
        sda_low = 1'b0;
        waitClk(8);
        checkOutput("ack driven before reset", {31'h0, sda_bus}, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-ack reset sdat released", {31'h0, sda_bus}, 32'h1);
        checkOutput("mid-ack reset data_out", {16'h0, data_out}, 32'h0);
        checkOutput("mid-ack reset busy", {31'h0, busy}, 32'h0);
        checkOutput("mid-ack reset data_valid", {31'h0, data_valid}, 32'h0);
        checkOutput("mid-ack reset error", {31'h0, error}, 32'h0);
        last_data = 16'h0000;
        waitClk(4);
        scl = 1'b1;
        waitClk(Q);
        rst_n = 1'b1;
        waitClk(Q);
        runVector(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
